// File: rtl/conv_encoder_stream_if.sv
// Handshake bundle between conv_encoder_stream, its show-ahead input FIFO and the rate matcher.
// The slave modport is the encoder's view; master is the environment driving it.
interface conv_encoder_stream_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 13
);
  logic              data_valid;
  logic [LEN_W-1:0]  block_len;
  logic [5:0]        tail_bits;
  logic              zero_tail;
  logic              blk_empty;
  logic [DATA_W-1:0] blk_data;
  logic              blk_data_rdreq;
  logic [DATA_W-1:0] q0;
  logic [DATA_W-1:0] q1;
  logic [DATA_W-1:0] q2;
  logic              q_valid;
  logic              rdreq_subblock;
  logic              computation_done;
  logic [LEN_W-1:0]  length_out;

  modport slave (
    input  data_valid, block_len, tail_bits, zero_tail, blk_empty, blk_data, rdreq_subblock,
    output blk_data_rdreq, q0, q1, q2, q_valid, computation_done, length_out
  );

  modport master (
    output data_valid, block_len, tail_bits, zero_tail, blk_empty, blk_data, rdreq_subblock,
    input  blk_data_rdreq, q0, q1, q2, q_valid, computation_done, length_out
  );
endinterface

// File: rtl/conv_encoder_stream.sv
// Word-serial K=7 rate-1/3 convolutional encoder (G 133/171/165) with tail-biting start and a show-ahead output buffer.
// Define CONV_ZERO_TAIL_EN to add the zero-tail mode (zero start state plus one flush word per block).
module conv_encoder_stream #(
  parameter int DATA_W    = 8,
  parameter int LEN_W     = 13,
  parameter int OUT_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  conv_encoder_stream_if.slave bus
);

  localparam int AW = $clog2(OUT_DEPTH);
  localparam int EW = 3 * DATA_W;

`ifdef CONV_ZERO_TAIL_EN
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
`endif

  typedef struct packed {
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic [5:0]        s;
  } enc_t;

  // s[0] holds the most recent bit (r1), s[5] the oldest (r6).
  function automatic enc_t encode(input logic [DATA_W-1:0] w, input logic [5:0] s_in);
    enc_t       r;
    logic [5:0] s;
    logic       b;
    r = '0;
    s = s_in;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      b       = w[i];
      r.d0[i] = b ^ s[1] ^ s[2] ^ s[4] ^ s[5];
      r.d1[i] = b ^ s[0] ^ s[1] ^ s[2] ^ s[5];
      r.d2[i] = b ^ s[0] ^ s[1] ^ s[3] ^ s[5];
      s       = {s[4:0], b};
    end
    r.s = s;
    return r;
  endfunction

  state_e            state_q, state_d;
  logic [5:0]        s_q, s_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [EW-1:0]     mem_q [OUT_DEPTH];
  logic [EW-1:0]     mem_d [OUT_DEPTH];
  logic [AW-1:0]     wr_q, wr_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [AW:0]       fill_q, fill_d;
  logic [EW-1:0]     hold_q, hold_d;
  logic              zt_q, zt_d;

  logic              buf_full;
  logic              q_vld;
  logic              push;
  logic              pop;
  logic              rdreq;
  logic [EW-1:0]     push_dat;
  logic [EW-1:0]     head;
  logic [DATA_W-1:0] enc_word;
  enc_t              enc;

  assign buf_full = (fill_q == (AW+1)'(OUT_DEPTH));
  assign q_vld    = (fill_q != '0);
  assign pop      = q_vld && bus.rdreq_subblock;

`ifdef CONV_ZERO_TAIL_EN
  assign enc_word = (state_q == FLUSH) ? '0 : bus.blk_data;
`else
  logic unused_zero_tail;
  assign unused_zero_tail = bus.zero_tail;
  assign enc_word = bus.blk_data;
`endif
  assign enc = encode(enc_word, s_q);

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    zt_d     = zt_q;
    push     = 1'b0;
    push_dat = {enc.d0, enc.d1, enc.d2};
    rdreq    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.data_valid) begin
          len_d = bus.block_len;
          cnt_d = '0;
          s_d   = bus.tail_bits;
          zt_d  = 1'b0;
`ifdef CONV_ZERO_TAIL_EN
          zt_d = bus.zero_tail;
          if (bus.zero_tail) s_d = '0;
`endif
          state_d = (bus.block_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        rdreq = !bus.blk_empty && !buf_full;
        if (rdreq) begin
          push  = 1'b1;
          s_d   = enc.s;
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) begin
`ifdef CONV_ZERO_TAIL_EN
            state_d = zt_q ? FLUSH : DONE;
`else
            state_d = DONE;
`endif
          end
        end
      end
`ifdef CONV_ZERO_TAIL_EN
      FLUSH: begin
        if (!buf_full) begin
          push    = 1'b1;
          s_d     = enc.s;
          state_d = DONE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output buffer: circular store; when empty the last shown entry is held on q0..q2.
  always_comb begin
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    fill_d = fill_q;
    head   = mem_q[rd_q];
    hold_d = q_vld ? head : hold_q;
    if (push) begin
      mem_d[wr_q] = push_dat;
      wr_d        = wr_q + AW'(1);
    end
    if (pop) rd_d = rd_q + AW'(1);
    if (push && !pop)      fill_d = fill_q + (AW+1)'(1);
    else if (!push && pop) fill_d = fill_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      zt_q    <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      fill_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      zt_q    <= zt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      fill_q  <= fill_d;
      hold_q  <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  logic [EW-1:0] q_all;
  assign q_all                = q_vld ? head : hold_q;
  assign bus.q0               = q_all[3*DATA_W-1 -: DATA_W];
  assign bus.q1               = q_all[2*DATA_W-1 -: DATA_W];
  assign bus.q2               = q_all[DATA_W-1 -: DATA_W];
  assign bus.q_valid          = q_vld;
  assign bus.blk_data_rdreq   = rdreq;
  assign bus.computation_done = (state_q == DONE);
  assign bus.length_out       = len_q;

endmodule
